// File: rtl/rng_pool.sv
// Decimates a free-running 16-bit random stream, packs sample pairs into 32-bit words
// and buffers them in a FWFT FIFO. Optional repetition health test: define RNG_POOL_HEALTH_EN.
module rng_pool #(
    parameter int DECIM     = 4,
    parameter int DEPTH     = 8,
    parameter int REP_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [15:0]              rng_i,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     health_fail
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [7:0]     DECIM_M1 = 8'(DECIM - 1);
    localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

    if (DECIM < 1 || DECIM > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REP_LIMIT < 2) begin : g_param_check
        $error("rng_pool: illegal parameter value");
    end

    logic [7:0]    r_cnt;
    logic          r_half;
    logic [15:0]   r_hi;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [31:0]   r_rd_data;

    logic          w_sample;
    logic          w_push;
    logic          w_pop;
    logic          w_trip;
    logic          w_inhibit;
    logic [31:0]   w_word;
    logic [AW-1:0] w_rptr_nx;

`ifdef RNG_POOL_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    logic [15:0]   r_prev;
    logic [RW-1:0] r_rep;
    logic          r_fail;
    logic [RW-1:0] w_rep_nxt;

    // A zero count means no previous sample, so the next sample always counts as 1.
    always_comb begin
        w_rep_nxt = RW'(1);
        if (r_rep != '0 && rng_i == r_prev) begin
            w_rep_nxt = (r_rep == REP_MAX) ? r_rep : r_rep + RW'(1);
        end
    end

    assign w_trip    = w_sample && (w_rep_nxt == REP_MAX);
    assign w_inhibit = r_fail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_rep  <= '0;
            r_fail <= 1'b0;
        end else if (flush) begin
            r_rep  <= '0;
            r_fail <= 1'b0;
        end else if (w_sample) begin
            r_prev <= rng_i;
            r_rep  <= w_rep_nxt;
            if (w_trip) r_fail <= 1'b1;
        end
    end

    assign health_fail = r_fail;
`else
    assign w_trip      = 1'b0;
    assign w_inhibit   = 1'b0;
    assign health_fail = 1'b0;
`endif

    assign w_sample  = enable && !w_inhibit && (r_cnt == DECIM_M1);
    assign w_word    = {r_hi, rng_i};
    assign w_push    = w_sample && r_half && !full && !w_trip;
    assign w_pop     = rd_valid && rd_ready;
    assign w_rptr_nx = r_rptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_half    <= 1'b0;
            r_hi      <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else if (flush) begin
            r_cnt   <= '0;
            r_half  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (enable) r_cnt <= (r_cnt == DECIM_M1) ? 8'd0 : r_cnt + 8'd1;
            if (w_trip) begin
                r_half  <= 1'b0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_sample) begin
                    if (!r_half) r_hi <= rng_i;
                    r_half <= !r_half;
                end
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= w_rptr_nx;
                unique case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_ONE;
                    2'b01:   r_level <= r_level - LVL_ONE;
                    default: r_level <= r_level;
                endcase
                // Head register tracks the oldest word; it holds its value once the FIFO drains.
                if (w_pop) begin
                    if (r_level > LVL_ONE) r_rd_data <= r_mem[w_rptr_nx];
                    else if (w_push)       r_rd_data <= w_word;
                end else if (w_push && r_level == '0) begin
                    r_rd_data <= w_word;
                end
            end
        end
    end

    assign rd_valid = (r_level != '0);
    assign full     = (r_level == LVL_FULL);
    assign level    = r_level;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_rng_pool.sv
// Self-checking bench for rng_pool: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rng_pool;

    localparam int DECIM     = 4;
    localparam int DEPTH     = 8;
    localparam int REP_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] rng_i;
    logic        enable;
    logic        flush;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  level;
    logic        full;
    logic        health_fail;

    rng_pool #(.DECIM(DECIM), .DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .rng_i(rng_i), .enable(enable), .flush(flush),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .full(full), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, sampling derived from a count of enabled edges.
    logic [31:0] m_q[$];
    int          m_en_edges;
    int          m_nsamp;
    logic [15:0] m_hi;
    logic [15:0] m_prev;
    int          m_rep;
    bit          m_hf;
    logic [31:0] m_rd;

    function automatic void model_reset();
        m_q.delete();
        m_en_edges = 0;
        m_nsamp    = 0;
        m_hi       = '0;
        m_prev     = '0;
        m_rep      = 0;
        m_hf       = 1'b0;
        m_rd       = '0;
    endfunction

    function automatic void model_edge();
        bit pop, push, trip, full_b;
        logic [31:0] w;
        if (flush) begin
            m_q.delete();
            m_en_edges = 0;
            m_nsamp    = 0;
            m_rep      = 0;
            m_hf       = 1'b0;
            return;
        end
        pop    = (m_q.size() > 0) && rd_ready;
        full_b = (m_q.size() == DEPTH);
        push   = 1'b0;
        trip   = 1'b0;
        w      = '0;
        if (enable) begin
            m_en_edges++;
            if ((m_en_edges % DECIM) == 0 && !m_hf) begin
`ifdef RNG_POOL_HEALTH_EN
                if (m_rep > 0 && rng_i == m_prev) m_rep = (m_rep < REP_LIMIT) ? m_rep + 1 : m_rep;
                else                              m_rep = 1;
                m_prev = rng_i;
                if (m_rep == REP_LIMIT) begin
                    trip = 1'b1;
                    m_hf = 1'b1;
                end
`endif
                if (trip) m_nsamp = 0;
                else if ((m_nsamp % 2) == 0) begin
                    m_hi = rng_i;
                    m_nsamp++;
                end else begin
                    w    = {m_hi, rng_i};
                    push = !full_b;
                    m_nsamp++;
                end
            end
        end
        if (trip) m_q.delete();
        else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(w);
        end
        if (m_q.size() > 0) m_rd = m_q[0];
    endfunction

    // True when the coming edge (with enable=1) samples the second half of a word.
    function automatic bit next_is_push();
        return ((m_en_edges + 1) % DECIM) == 0 && (m_nsamp % 2) == 1 && !m_hf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_q.size() > 0});
        chk("level", {28'd0, level}, 32'(m_q.size()));
        chk("full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        chk("rd_data", rd_data, m_rd);
        chk("health_fail", {31'd0, health_fail}, {31'd0, m_hf});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s1, s2;
        logic [31:0] exp2;
        bit found;

        reset_n  = 1'b0;
        rng_i    = '0;
        enable   = 1'b0;
        flush    = 1'b0;
        rd_ready = 1'b0;
        model_reset();
        #3;
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_level", {28'd0, level}, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_health", {31'd0, health_fail}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();

        // First word: rng_i equals the edge number since enable rose
        enable = 1'b1;
        for (int k = 1; k <= 2 * DECIM; k++) begin
            rng_i = 16'(k);
            step();
        end
        chk("first_valid", {31'd0, rd_valid}, 32'd1);
        chk("first_data", rd_data, 32'h0004_0008);
        chk("first_level", {28'd0, level}, 32'd1);

        // Fill to 20 words total with no reads; excess words are dropped
        for (int i = 0; i < 19 * 2 * DECIM; i++) begin
            rng_i = 16'($urandom);
            step();
        end
        chk("fill_level", {28'd0, level}, 32'd8);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_head", rd_data, 32'h0004_0008);
        enable   = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        chk("drain_level", {28'd0, level}, 32'd0);
        chk("drain_valid", {31'd0, rd_valid}, 32'd0);

        // Simultaneous push and pop at level 3
        rd_ready = 1'b0;
        enable   = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (m_q.size() == 3 && next_is_push()) begin
                found = 1'b1;
                break;
            end
            rng_i = 16'($urandom);
            step();
        end
        chk("pushpop_setup", {31'd0, found}, 32'd1);
        if (found) begin
            exp2     = m_q[1];
            rd_ready = 1'b1;
            rng_i    = 16'($urandom);
            step();
            rd_ready = 1'b0;
            chk("pushpop_level", {28'd0, level}, 32'd3);
            chk("pushpop_data", rd_data, exp2);
        end

        // Flush on a second-half sample edge
        found = 1'b0;
        for (int n = 0; n < 4 * DECIM; n++) begin
            if (next_is_push()) begin
                found = 1'b1;
                break;
            end
            rng_i = 16'($urandom);
            step();
        end
        chk("flush_setup", {31'd0, found}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", {31'd0, rd_valid}, 32'd0);
        chk("flush_level", {28'd0, level}, 32'd0);
        s1 = '0;
        s2 = '0;
        for (int j = 1; j <= 2 * DECIM; j++) begin
            rng_i = 16'($urandom);
            if (j == DECIM)     s1 = rng_i;
            if (j == 2 * DECIM) s2 = rng_i;
            step();
        end
        chk("flush_word", rd_data, {s1, s2});
        chk("flush_word_level", {28'd0, level}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            rd_ready = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 99) == 0);
            rng_i    = ($urandom_range(0, 3) == 0) ? rng_i : 16'($urandom);
            step();
        end
        flush = 1'b0;

`ifdef RNG_POOL_HEALTH_EN
        flush = 1'b1;
        step();
        flush    = 1'b0;
        enable   = 1'b1;
        rd_ready = 1'b0;
        rng_i    = 16'hA5A5;
        for (int i = 0; i < REP_LIMIT * DECIM; i++) step();
        chk("health_set", {31'd0, health_fail}, 32'd1);
        chk("health_empty", {28'd0, level}, 32'd0);
        for (int i = 0; i < 4 * DECIM; i++) step();
        chk("health_no_push", {28'd0, level}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("health_clear", {31'd0, health_fail}, 32'd0);
        for (int i = 0; i < 2 * DECIM; i++) begin
            rng_i = 16'($urandom);
            step();
        end
        chk("health_resume", {28'd0, level}, 32'd1);
`endif

        // Asynchronous reset with three words held
        enable   = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        rd_ready = 1'b0;
        enable   = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (m_q.size() == 3) begin
                found = 1'b1;
                break;
            end
            rng_i = 16'($urandom);
            step();
        end
        chk("reset_setup", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_valid", {31'd0, rd_valid}, 32'd0);
        chk("midreset_level", {28'd0, level}, 32'd0);
        chk("midreset_data", rd_data, 32'd0);
        chk("midreset_full", {31'd0, full}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3 * DECIM; i++) begin
            rng_i = 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
